// File: rtl/jtagg_capture_ctrl.sv
// Captures JTAGG user-register shifts into the system clock domain and hands each
// completed frame to a downstream consumer over a valid/ready handshake.
module jtagg_capture_ctrl #(
  parameter int unsigned C_data_len    = 64,
  parameter int unsigned C_cnt_bits    = 8,
  parameter int unsigned C_sync_stages = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  jtck,
  input  logic                  jtdi,
  input  logic                  jshift,
  input  logic                  jupdate,
  input  logic                  jce1,
  input  logic                  jrstn,
  output logic [C_data_len-1:0] data_out,
  output logic [C_cnt_bits-1:0] bits_out,
  output logic                  overflow,
  output logic                  valid,
  input  logic                  ready,
  output logic [7:0]            dropped,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  localparam logic [C_cnt_bits-1:0] CNT_MAX = '1;
  localparam logic [C_cnt_bits-1:0] CNT_LEN = C_cnt_bits'(C_data_len);

  // bit order: {jrstn, jce1, jupdate, jshift, jtdi, jtck}
  logic [5:0] sync_q [C_sync_stages];
  logic       tck_prev_q, upd_prev_q;

  state_t state_q, state_d;

  logic [C_data_len-1:0] shreg_q, shreg_d;
  logic [C_cnt_bits-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [C_data_len-1:0] data_q, data_d;
  logic [C_cnt_bits-1:0] bits_q, bits_d;
  logic                  ovfo_q, ovfo_d;
  logic                  valid_q, valid_d;
  logic [7:0]            drop_q, drop_d;

  logic s_tck, s_tdi, s_shift, s_upd, s_ce1, s_rstn;
  logic tck_rise, upd_rise, tap_rst, qual, commit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < C_sync_stages; i++) sync_q[i] <= '0;
      tck_prev_q <= 1'b0;
      upd_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {jrstn, jce1, jupdate, jshift, jtdi, jtck};
      for (int unsigned i = 1; i < C_sync_stages; i++) sync_q[i] <= sync_q[i-1];
      tck_prev_q <= s_tck;
      upd_prev_q <= s_upd;
    end
  end

  always_comb begin
    {s_rstn, s_ce1, s_upd, s_shift, s_tdi, s_tck} = sync_q[C_sync_stages-1];
    tck_rise = s_tck & ~tck_prev_q;
    upd_rise = s_upd & ~upd_prev_q;
    tap_rst  = ~s_rstn;
    qual     = tck_rise & s_shift & s_ce1;
    commit   = (state_q == S_COMMIT) & ~tap_rst;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the extra COMMIT cycle sets the update-to-valid latency
  always_comb begin
    state_d = state_q;
    if (tap_rst) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (qual) state_d = S_SHIFT;
        S_SHIFT:  if (upd_rise) state_d = S_COMMIT;
        S_COMMIT: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_SHIFT);
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    bits_d  = bits_q;
    ovfo_d  = ovfo_q;
    valid_d = valid_q;
    drop_d  = drop_q;

    if (tap_rst) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (qual) begin
            shreg_d = {s_tdi, shreg_q[C_data_len-1:1]};
            cnt_d   = {{(C_cnt_bits-1){1'b0}}, 1'b1};
            ovf_d   = 1'b0;
          end
        end
        S_SHIFT: begin
          if (qual) begin
            shreg_d = {s_tdi, shreg_q[C_data_len-1:1]};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_q >= CNT_LEN) ovf_d = 1'b1;
          end
        end
        S_COMMIT: cnt_d = '0;
        default: ;
      endcase
    end

    if (commit) begin
      if (!valid_q || ready) begin
        data_d  = shreg_q;
        bits_d  = cnt_q;
        ovfo_d  = ovf_q;
        valid_d = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      bits_q  <= '0;
      ovfo_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
      ovfo_q  <= ovfo_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign data_out = data_q;
  assign bits_out = bits_q;
  assign overflow = ovfo_q;
  assign valid    = valid_q;
  assign dropped  = drop_q;

endmodule

// File: tb/tb_jtagg_capture_ctrl.sv
// Directed bench for jtagg_capture_ctrl: table of frames plus hand-written
// sequences for TAP reset, zero-bit updates, qualifier gating and async reset.
module tb_jtagg_capture_ctrl;

  localparam int unsigned DL = 64;
  localparam int unsigned CB = 8;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          jtck = 1'b0, jtdi = 1'b0, jshift = 1'b0, jupdate = 1'b0, jce1 = 1'b0;
  logic          jrstn = 1'b1;
  logic          ready = 1'b0;
  logic [DL-1:0] data_out;
  logic [CB-1:0] bits_out;
  logic          overflow, valid, busy;
  logic [7:0]    dropped;

  int n_tests = 0;
  int n_fail  = 0;
  logic v_pre, v_post;

  jtagg_capture_ctrl #(
    .C_data_len   (DL),
    .C_cnt_bits   (CB),
    .C_sync_stages(SS)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .jtck    (jtck),
    .jtdi    (jtdi),
    .jshift  (jshift),
    .jupdate (jupdate),
    .jce1    (jce1),
    .jrstn   (jrstn),
    .data_out(data_out),
    .bits_out(bits_out),
    .overflow(overflow),
    .valid   (valid),
    .ready   (ready),
    .dropped (dropped),
    .busy    (busy)
  );

  always #20 clk = ~clk;

  typedef struct {
    int           n;
    logic [127:0] din;
    bit           rdy;
    bit           ack;
    bit           lat;
    logic [63:0]  exp_data;
    int           mbits;
    int           exp_bits;
    bit           exp_valid;
    bit           exp_ovf;
    int           exp_drop;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tck_bit(input logic b);
    jtdi = b;
    wait_clk(4);
    jtck = 1'b1;
    wait_clk(4);
    jtck = 1'b0;
  endtask

  task automatic shift_frame(input logic [127:0] d, input int n);
    jshift = 1'b1;
    jce1   = 1'b1;
    for (int i = 0; i < n; i++) tck_bit(d[i]);
    wait_clk(4);
    jshift = 1'b0;
    jce1   = 1'b0;
    wait_clk(2);
  endtask

  // ready, when requested, is high only for the clock edge that performs the commit
  task automatic update_frame(input bit rdy);
    wait_clk(1);
    jupdate = 1'b1;
    wait_clk(3);
    v_pre = valid;
    if (rdy) ready = 1'b1;
    wait_clk(1);
    v_post = valid;
    ready = 1'b0;
    wait_clk(4);
    jupdate = 1'b0;
    wait_clk(6);
  endtask

  task automatic ack();
    ready = 1'b1;
    wait_clk(1);
    ready = 1'b0;
    chk("ack_valid_clear", valid, 0);
  endtask

  function automatic logic [63:0] top_mask(input int m);
    logic [63:0] ones;
    ones = '1;
    return ~(ones >> m);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t70;
    logic [63:0]  m;

    t70 = {58'd0, 6'h2A, 64'hFEDCBA9876543210};
    tv[0] = '{8,  128'hA5,               0, 1, 1, 64'hA500_0000_0000_0000, 8,  8,  1, 0, 0};
    tv[1] = '{64, 128'h0123456789ABCDEF, 0, 1, 0, 64'h0123_4567_89AB_CDEF, 64, 64, 1, 0, 0};
    tv[2] = '{70, t70,                   0, 1, 0, t70[69:6],               64, 70, 1, 1, 0};
    tv[3] = '{8,  128'h3C,               0, 0, 0, 64'h3C00_0000_0000_0000, 8,  8,  1, 0, 0};
    tv[4] = '{4,  128'h5,                0, 0, 0, 64'h3C00_0000_0000_0000, 8,  8,  1, 0, 1};
    tv[5] = '{16, 128'hBEEF,             0, 1, 0, 64'h3C00_0000_0000_0000, 8,  8,  1, 0, 2};
    tv[6] = '{12, 128'hABC,              0, 0, 0, 64'hABC0_0000_0000_0000, 12, 12, 1, 0, 2};
    tv[7] = '{8,  128'h81,               1, 1, 0, 64'h8100_0000_0000_0000, 8,  8,  1, 0, 2};

    wait_clk(3);
    chk("rst_data", data_out, 0);
    chk("rst_bits", bits_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", valid, 0);
    chk("rst_drop", dropped, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 8; i++) begin
      shift_frame(tv[i].din, tv[i].n);
      update_frame(tv[i].rdy);
      m = top_mask(tv[i].mbits);
      chk($sformatf("v%0d_valid", i), valid, tv[i].exp_valid);
      chk($sformatf("v%0d_data", i), data_out & m, tv[i].exp_data & m);
      chk($sformatf("v%0d_bits", i), bits_out, tv[i].exp_bits);
      chk($sformatf("v%0d_ovf", i), overflow, tv[i].exp_ovf);
      chk($sformatf("v%0d_drop", i), dropped, tv[i].exp_drop);
      chk($sformatf("v%0d_busy", i), busy, 0);
      if (tv[i].lat) begin
        chk("lat_before_commit", v_pre, 0);
        chk("lat_at_commit", v_post, 1);
      end
      if (tv[i].ack) ack();
    end

    // TAP reset mid-frame discards the partial frame
    jshift = 1'b1;
    jce1   = 1'b1;
    for (int i = 0; i < 5; i++) tck_bit(1'b1);
    wait_clk(2);
    chk("tap_busy_before", busy, 1);
    jrstn = 1'b0;
    for (int i = 0; i < 4; i++) tck_bit(1'b1);
    chk("tap_busy_during", busy, 0);
    jrstn = 1'b1;
    wait_clk(4);
    chk("tap_busy_after", busy, 0);
    shift_frame(128'h5, 3);
    update_frame(0);
    m = top_mask(3);
    chk("tap_valid", valid, 1);
    chk("tap_bits", bits_out, 3);
    chk("tap_data", data_out & m, 64'hA000_0000_0000_0000 & m);
    chk("tap_ovf", overflow, 0);
    ack();

    // Update with no bits shifted produces nothing
    update_frame(0);
    chk("zero_valid", valid, 0);
    chk("zero_drop", dropped, 2);

    // TCK edges without both jshift and jce1 must not shift
    jshift = 1'b0;
    jce1   = 1'b1;
    for (int i = 0; i < 3; i++) tck_bit(1'b1);
    jshift = 1'b1;
    jce1   = 1'b0;
    for (int i = 0; i < 3; i++) tck_bit(1'b1);
    jshift = 1'b0;
    wait_clk(4);
    chk("qual_busy", busy, 0);
    shift_frame(128'hA, 4);
    update_frame(0);
    m = top_mask(4);
    chk("qual_valid", valid, 1);
    chk("qual_bits", bits_out, 4);
    chk("qual_data", data_out & m, 64'hA000_0000_0000_0000 & m);
    ack();

    // Asynchronous reset mid-shift with a frame pending
    shift_frame(128'h77, 8);
    update_frame(0);
    chk("arst_pre_valid", valid, 1);
    jshift = 1'b1;
    jce1   = 1'b1;
    for (int i = 0; i < 3; i++) tck_bit(1'b1);
    wait_clk(2);
    chk("arst_pre_busy", busy, 1);
    @(posedge clk);
    #10 rstn = 1'b0;
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_bits", bits_out, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_valid", valid, 0);
    chk("arst_drop", dropped, 0);
    chk("arst_busy", busy, 0);
    wait_clk(2);
    jshift = 1'b0;
    jce1   = 1'b0;
    rstn   = 1'b1;
    wait_clk(4);
    shift_frame(128'h5A, 8);
    update_frame(0);
    chk("post_valid", valid, 1);
    chk("post_data", data_out, 64'h5A00_0000_0000_0000);
    chk("post_bits", bits_out, 8);
    chk("post_ovf", overflow, 0);
    chk("post_drop", dropped, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
